// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter for a single-port data RAM
// Serialises CPU and DMA word accesses through one latched transaction at a time.
module ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  state_t            state, state_nxt;
  logic              lat_we;
  logic              owner;
  logic              last_grant;
  logic              grant_dma;
  logic              any_req;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // On a tie the requester that did not win last time gets the RAM.
  assign any_req   = cpu_req | dma_req;
  assign grant_dma = dma_req & (~cpu_req | (last_grant == OWNER_CPU));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      owner      <= OWNER_CPU;
      last_grant <= OWNER_DMA;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        owner      <= grant_dma;
        last_grant <= grant_dma;
        lat_we     <= grant_dma ? dma_we    : cpu_we;
        lat_addr   <= grant_dma ? dma_addr  : cpu_addr;
        lat_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
      end
      if (state == CAPTURE) begin
        if (owner == OWNER_DMA) dma_rdata <= ram_data_out;
        else                    cpu_rdata <= ram_data_out;
      end
    end
  end

  // RAM strobes and acks decode straight from state so reset drops them at once.
  always_comb begin
    state_nxt   = state;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    cpu_ack     = 1'b0;
    dma_ack     = 1'b0;
    ram_addr    = lat_addr;
    ram_data_in = lat_wdata;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        ram_we    = lat_we;
        ram_re    = ~lat_we;
        state_nxt = lat_we ? ACK : CAPTURE;
      end
      CAPTURE: begin
        state_nxt = ACK;
      end
      ACK: begin
        cpu_ack   = (owner == OWNER_CPU);
        dma_ack   = (owner == OWNER_DMA);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed table-driven bench for ram_arbiter
// A behavioural one-cycle-latency RAM sits behind the arbiter.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [11:0] cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_ack, dma_ack, ram_we, ram_re;
  logic [31:0] cpu_rdata, dma_rdata, ram_data_in;
  logic [11:0] ram_addr;
  bit   [31:0] mem [0:4095];
  bit   [31:0] ram_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  ram_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_re(ram_re),
    .ram_data_out(ram_q)
  );

  typedef struct {
    logic        c_req, c_we;
    logic [11:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req, d_we;
    logic [11:0] d_addr;
    logic [31:0] d_wdata;
    logic        exp_dma;
    logic        exp_we;
    logic [11:0] exp_addr;
    int          exp_lat;
    logic [31:0] exp_crd, exp_drd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  order;
    int          ack_cnt, both_cnt, bad_ack;

    vecs[0] = '{1,1,12'h010,32'hDEADBEEF, 0,0,12'h000,32'h0,        0,1,12'h010,2, 32'h0,        32'h0};
    vecs[1] = '{1,0,12'h010,32'h0,        0,0,12'h000,32'h0,        0,0,12'h010,3, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{0,0,12'h000,32'h0,        1,1,12'h020,32'h12345678, 1,1,12'h020,2, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1,0,12'h020,32'h0,        1,1,12'h030,32'hA5A5A5A5, 0,0,12'h020,3, 32'h12345678, 32'h0};
    vecs[4] = '{1,1,12'h040,32'h11111111, 1,0,12'h010,32'h0,        1,0,12'h010,3, 32'h12345678, 32'hDEADBEEF};
    vecs[5] = '{1,1,12'hFFF,32'hCAFEF00D, 1,0,12'h020,32'h0,        0,1,12'hFFF,2, 32'h12345678, 32'hDEADBEEF};
    vecs[6] = '{1,0,12'hFFF,32'h0,        1,0,12'hFFF,32'h0,        1,0,12'hFFF,3, 32'h12345678, 32'hCAFEF00D};
    vecs[7] = '{1,0,12'hFFF,32'h0,        0,0,12'h000,32'h0,        0,0,12'hFFF,3, 32'hCAFEF00D, 32'hCAFEF00D};

    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("reset_strobes", {60'b0, cpu_ack, dma_ack, ram_we, ram_re}, 64'h0);
    check("reset_ram_bus", {20'b0, ram_addr, ram_data_in}, 64'h0);
    check("reset_rdata", {cpu_rdata, dma_rdata}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      cpu_req = vecs[v].c_req; cpu_we = vecs[v].c_we;
      cpu_addr = vecs[v].c_addr; cpu_wdata = vecs[v].c_wdata;
      dma_req = vecs[v].d_req; dma_we = vecs[v].d_we;
      dma_addr = vecs[v].d_addr; dma_wdata = vecs[v].d_wdata;
      for (int k = 1; k <= 5; k++) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_cyc%0d", v, k),
              {48'b0, ram_we, ram_re, cpu_ack, dma_ack, ram_addr},
              {48'b0, (k == 1) && vecs[v].exp_we, (k == 1) && !vecs[v].exp_we,
               (k == vecs[v].exp_lat) && !vecs[v].exp_dma,
               (k == vecs[v].exp_lat) && vecs[v].exp_dma, vecs[v].exp_addr});
        if (k == vecs[v].exp_lat) begin
          check($sformatf("vec%0d_rdata", v), {cpu_rdata, dma_rdata},
                {vecs[v].exp_crd, vecs[v].exp_drd});
          cpu_req = 0;
          dma_req = 0;
        end
      end
    end

    // Inputs changing during ACCESS must not disturb the latched write.
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h020; cpu_wdata = 32'hBBBB0000;
    @(posedge clk);
    @(negedge clk);
    cpu_addr = 12'h3FF; cpu_wdata = 32'hFFFFFFFF; cpu_we = 0;
    check("hold_access", {19'b0, ram_we, ram_addr, ram_data_in}, {19'b0, 1'b1, 12'h020, 32'hBBBB0000});
    @(posedge clk);
    @(negedge clk);
    check("hold_ack", {18'b0, cpu_ack, ram_we, ram_addr, ram_data_in}, {18'b0, 2'b10, 12'h020, 32'hBBBB0000});
    cpu_req = 0;
    @(negedge clk);
    check("hold_mem", {mem[12'h020], mem[12'h3FF]}, {32'hBBBB0000, 32'h0});

    // Continuous re-request from both sides alternates grants.
    do_reset();
    check("reset_clears_rdata", {cpu_rdata, dma_rdata}, 64'h0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h100; cpu_wdata = 32'h1;
    dma_req = 1; dma_we = 1; dma_addr = 12'h200; dma_wdata = 32'h2;
    order = '0; ack_cnt = 0; both_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_ack && dma_ack) both_cnt++;
      if (cpu_ack || dma_ack) begin
        ack_cnt++;
        order = {order[2:0], dma_ack};
      end
    end
    idle_inputs();
    check("rr_ack_count", 64'(ack_cnt), 64'd4);
    check("rr_order", {60'b0, order}, {60'b0, 4'b0101});
    check("ack_exclusive", 64'(both_cnt), 64'd0);

    // Reset in the ACCESS cycle of a DMA write abandons it.
    do_reset();
    @(negedge clk);
    dma_req = 1; dma_we = 1; dma_addr = 12'h050; dma_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    check("abort_pre_we", {63'b0, ram_we}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_async_drop", {51'b0, ram_we, ram_addr}, 64'h0);
    dma_req = 0;
    bad_ack = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dma_ack) bad_ack++;
    end
    check("abort_no_ack", 64'(bad_ack), 64'd0);
    check("abort_no_write", {32'b0, mem[12'h050]}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    dma_req = 1; dma_we = 0; dma_addr = 12'h030;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("post_abort_cyc%0d", k), {50'b0, ram_re, cpu_ack, ram_addr},
            {50'b0, k == 1, k == 3, 12'h010});
      check($sformatf("post_abort_dma_ack%0d", k), {63'b0, dma_ack}, 64'd0);
      if (k == 3) begin
        check("post_abort_rdata", {32'b0, cpu_rdata}, {32'b0, 32'hDEADBEEF});
        idle_inputs();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
